tcdm_master_adapter: RTL and testbench

//  Master-side front end of tcdm_interconnect; one instance per master port.

---
 rtl/tcdm_adapter_pkg.sv | 20 ++
 rtl/tcdm_adapter_fifo.sv | 60 ++++++
 rtl/tcdm_master_adapter.sv | 111 +++++++++++
 tb/tb_tcdm_master_adapter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_adapter_pkg.sv
// Shared types and width helpers for the TCDM master adapter.
// tcdm_req_t is the request FIFO entry: one complete TCDM request beat.
package tcdm_adapter_pkg;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    localparam int TcdmAddrWidth = 32;
    localparam int TcdmDataWidth = 32;
    localparam int TcdmBeWidth   = be_width(TcdmDataWidth);

    typedef struct packed {
        logic [TcdmAddrWidth-1:0] addr;
        logic                     wen;
        logic [TcdmDataWidth-1:0] wdata;
        logic [TcdmBeWidth-1:0]   be;
    } tcdm_req_t;

endpackage

// File: rtl/tcdm_adapter_fifo.sv
// Synchronous FIFO with combinational head read and full/empty/usage status.
// Pushes while full and pops while empty are ignored, regardless of the other side.
module tcdm_adapter_fifo #(
    parameter type T        = logic,
    parameter int  Depth    = 2,
    parameter int  CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  T                    data_i,
    input  logic                pop_i,
    output T                    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] usage_o
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    T                    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr_reg;
    logic [PtrWidth-1:0] rd_ptr_reg;
    logic [CntWidth-1:0] cnt_reg;
    logic                push_ok;
    logic                pop_ok;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_reg == CntWidth'(Depth));
    assign empty_o = (cnt_reg == '0);
    assign usage_o = cnt_reg;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push_ok, pop_ok})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible past the counters.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_reg] <= data_i;
    end

endmodule

// File: rtl/tcdm_master_adapter.sv
// Master-side TCDM front end: valid/ready requests in, req/gnt out, rvld/rdata
// collected into a back-pressurable response stream with read credits.
module tcdm_master_adapter
    import tcdm_adapter_pkg::*;
#(
    parameter int AddrWidth = TcdmAddrWidth,
    parameter int DataWidth = TcdmDataWidth,
    parameter int ReqDepth  = 2,
    parameter int RspDepth  = 2,
    localparam int BeWidth  = be_width(DataWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_wen_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 req_o,
    output logic [AddrWidth-1:0] add_o,
    output logic                 wen_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic [BeWidth-1:0]   be_o,
    input  logic                 gnt_i,
    input  logic                 rvld_i,
    input  logic [DataWidth-1:0] rdata_i
);

    tcdm_req_t                       req_in;
    tcdm_req_t                       req_head;
    logic                            req_full;
    logic                            req_empty;
    logic [$clog2(ReqDepth+1)-1:0]   req_usage;
    logic [DataWidth-1:0]            rsp_head;
    logic                            rsp_full;
    logic                            rsp_empty;
    logic [$clog2(RspDepth+1)-1:0]   rsp_usage;
    logic                            rsp_push_raw;
    logic                            credit_ok;
    logic                            grant;
    logic                            infl_rd_reg;

    assign req_in = '{addr: req_addr_i, wen: req_wen_i, wdata: req_wdata_i, be: req_be_i};

    tcdm_adapter_fifo #(
        .T     (tcdm_req_t),
        .Depth (ReqDepth)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_valid_i && !req_full),
        .data_i  (req_in),
        .pop_i   (grant),
        .data_o  (req_head),
        .full_o  (req_full),
        .empty_o (req_empty),
        .usage_o (req_usage)
    );

    assign req_ready_o = int'(req_usage) < ReqDepth;

    // A read may only go out if a response slot is free after counting the
    // queued responses and the read whose rvld_i is still pending.
    assign credit_ok = req_head.wen || ((int'(rsp_usage) + int'(infl_rd_reg)) < RspDepth);
    assign req_o     = !req_empty && credit_ok;
    assign grant     = req_o && gnt_i;

    assign add_o   = req_empty ? '0 : req_head.addr;
    assign wen_o   = !req_empty && req_head.wen;
    assign wdata_o = req_empty ? '0 : req_head.wdata;
    assign be_o    = req_empty ? '0 : req_head.be;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) infl_rd_reg <= 1'b0;
        else         infl_rd_reg <= grant && !req_head.wen;
    end

    // rvld_i for writes or with nothing in flight is simply not pushed.
    assign rsp_push_raw = rvld_i && infl_rd_reg;

    tcdm_adapter_fifo #(
        .T     (logic [DataWidth-1:0]),
        .Depth (RspDepth)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rsp_push_raw && !rsp_full),
        .data_i  (rdata_i),
        .pop_i   (rsp_ready_i),
        .data_o  (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .usage_o (rsp_usage)
    );

    assign rsp_valid_o = !rsp_empty;
    assign rsp_rdata_o = rsp_empty ? '0 : rsp_head;

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_o && !gnt_i) |=> (req_o && $stable(add_o) && $stable(wen_o)
                               && $stable(wdata_o) && $stable(be_o)));
    a_rsp_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_push_raw && rsp_full));
    a_gnt_with_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(gnt_i && !req_o));

endmodule

// File: tb/tb_tcdm_master_adapter.sv
// Directed and random checks of tcdm_master_adapter against a TCDM memory
// responder and hand-computed read values.
module tb_tcdm_master_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_wen_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_be_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        req_o;
    logic [31:0] add_o;
    logic        wen_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i;
    logic        rvld_i;
    logic [31:0] rdata_i;

    always #5 clk_i = ~clk_i;

    tcdm_master_adapter #(
        .AddrWidth (32),
        .DataWidth (32),
        .ReqDepth  (2),
        .RspDepth  (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_wen_i   (req_wen_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .req_o       (req_o),
        .add_o       (add_o),
        .wen_o       (wen_o),
        .wdata_o     (wdata_o),
        .be_o        (be_o),
        .gnt_i       (gnt_i),
        .rvld_i      (rvld_i),
        .rdata_i     (rdata_i)
    );

    int          tests_run = 0;
    int          tests_failed = 0;
    logic        gnt_en = 1'b0;
    logic        gnt_rand = 1'b0;
    int          grants = 0;
    int          rd_grants = 0;
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_q [$];
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;
    logic [31:0] slave_cur;
    logic [31:0] ref_cur;
    int          g0;
    int          rd0;
    int          rsp_cnt;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // TCDM memory: grant decided at the negedge, rvld_i/rdata_i one cycle later.
    initial begin
        gnt_i = 1'b0;
        rvld_i = 1'b0;
        rdata_i = '0;
        forever begin
            @(negedge clk_i);
            rvld_i = pend;
            rdata_i = pend_data;
            gnt_i = req_o && gnt_en && (!gnt_rand || ($urandom_range(1, 0) == 1));
            pend = gnt_i;
            pend_data = 32'hBAD0_0BAD;
            if (gnt_i) begin
                slave_cur = slave_mem.exists(add_o) ? slave_mem[add_o] : init_word(add_o);
                grants++;
                if (wen_o) slave_mem[add_o] = merge(slave_cur, wdata_o, be_o);
                else begin
                    pend_data = slave_cur;
                    rd_grants++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] be);
        req_valid_i = 1'b1;
        req_addr_i = a;
        req_wen_i = w;
        req_wdata_i = d;
        req_be_i = be;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] exp);
        bit seen = 0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rsp_valid_o) begin
                check(tag, rsp_rdata_o, exp);
                seen = 1;
            end
            step();
        end
        if (!seen) begin
            tests_run++;
            assert (seen) else begin
                tests_failed++;
                $error("FAIL %s: observed no response expected %h", tag, exp);
            end
        end
    endtask

    initial begin
        slave_mem[32'h40] = 32'hDEAD_BEEF;
        repeat (3) step();
        rst_ni = 1'b1;
        check("rst_req_o", req_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_add", add_o, 0);
        check("rst_wen", wen_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_be", be_o, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        gnt_en = 1'b1;

        // T1 single read, minimum latency
        step();
        send(32'h40, 1'b0, 32'h0, 4'hF);
        check("t1_ready", req_ready_o, 1);
        step();
        req_valid_i = 1'b0;
        check("t1_req", req_o, 1);
        check("t1_add", add_o, 32'h40);
        step();
        check("t1_no_bypass", rsp_valid_o, 0);
        step();
        check("t1_rsp_valid", rsp_valid_o, 1);
        check("t1_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        rsp_ready_i = 1'b1;
        step();
        check("t1_rsp_done", rsp_valid_o, 0);
        rsp_ready_i = 1'b0;

        // T2 partial write then read of the same word
        step();
        send(32'h80, 1'b1, 32'h1234_5678, 4'b0011);
        step();
        send(32'h80, 1'b0, 32'h0, 4'hF);
        step();
        req_valid_i = 1'b0;
        check("t2_no_wr_rsp_a", rsp_valid_o, 0);
        step();
        check("t2_no_wr_rsp_b", rsp_valid_o, 0);
        expect_rsp("t2_rd", 32'h0080_5678);
        check("t2_single_rsp", rsp_valid_o, 0);
        rsp_ready_i = 1'b0;

        // T3 credit stall with three reads and a blocked response stream
        g0 = grants;
        step();
        send(32'h100, 1'b0, 32'h0, 4'hF);
        step();
        send(32'h104, 1'b0, 32'h0, 4'hF);
        step();
        send(32'h108, 1'b0, 32'h0, 4'hF);
        step();
        req_valid_i = 1'b0;
        check("t3_no_credit", req_o, 0);
        step();
        step();
        check("t3_two_grants", grants - g0, 2);
        check("t3_stall", req_o, 0);
        check("t3_rsp_valid", rsp_valid_o, 1);
        check("t3_r0", rsp_rdata_o, 32'h0100_FEFF);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("t3_release", req_o, 1);
        check("t3_release_add", add_o, 32'h108);
        expect_rsp("t3_r1", 32'h0104_FEFB);
        expect_rsp("t3_r2", 32'h0108_FEF7);
        check("t3_three_grants", grants - g0, 3);
        rsp_ready_i = 1'b0;

        // T4 grant stall holds the request and fills the request FIFO
        gnt_en = 1'b0;
        g0 = grants;
        step();
        send(32'h200, 1'b0, 32'h0, 4'hF);
        step();
        send(32'h204, 1'b0, 32'h0, 4'hF);
        check("t4_req", req_o, 1);
        check("t4_add", add_o, 32'h200);
        step();
        send(32'h208, 1'b0, 32'h0, 4'hF);
        check("t4_full", req_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_req", req_o, 1);
            check("t4_hold_add", add_o, 32'h200);
            check("t4_hold_full", req_ready_o, 0);
        end
        req_valid_i = 1'b0;
        check("t4_no_grants", grants - g0, 0);
        gnt_en = 1'b1;
        expect_rsp("t4_first", 32'h0200_FDFF);
        expect_rsp("t4_second", 32'h0204_FDFB);
        check("t4_drained", rsp_valid_o, 0);
        rsp_ready_i = 1'b0;

        // T5 reset during the rvld_i cycle of a granted read
        rsp_ready_i = 1'b1;
        step();
        send(32'h300, 1'b0, 32'h0, 4'hF);
        step();
        send(32'h304, 1'b0, 32'h0, 4'hF);
        gnt_en = 1'b0;
        step();
        req_valid_i = 1'b0;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("t5_rsp_valid", rsp_valid_o, 0);
        check("t5_req_o", req_o, 0);
        check("t5_req_ready", req_ready_o, 1);
        step();
        check("t5_rvld_ignored", rsp_valid_o, 0);
        gnt_en = 1'b1;

        // T6 random traffic against a request-order scoreboard
        ref_mem = slave_mem;
        exp_q.delete();
        rd0 = rd_grants;
        rsp_cnt = 0;
        gnt_rand = 1'b1;
        for (int cyc = 0; cyc < 10200; cyc++) begin
            step();
            rsp_ready_i = (cyc < 10000) ? 1'($urandom_range(1, 0)) : 1'b1;
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    assert (exp_q.size() != 0) else begin
                        tests_failed++;
                        $error("FAIL t6_extra_rsp: observed %h expected no response", rsp_rdata_o);
                    end
                end else begin
                    check("t6_rsp", rsp_rdata_o, exp_q.pop_front());
                end
            end
            req_valid_i = (cyc < 10000) && ($urandom_range(1, 0) == 1);
            req_addr_i = 32'h400 + 4 * $urandom_range(7, 0);
            req_wen_i = 1'($urandom_range(1, 0));
            req_wdata_i = $urandom;
            req_be_i = 4'($urandom_range(15, 0));
            if (req_valid_i && req_ready_o) begin
                ref_cur = ref_mem.exists(req_addr_i) ? ref_mem[req_addr_i] : init_word(req_addr_i);
                if (req_wen_i) ref_mem[req_addr_i] = merge(ref_cur, req_wdata_i, req_be_i);
                else exp_q.push_back(ref_cur);
            end
        end
        req_valid_i = 1'b0;
        check("t6_all_returned", exp_q.size(), 0);
        check("t6_rsp_vs_grants", rsp_cnt, rd_grants - rd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
